// File: rtl/mux_arb_m.sv
// Two-requester round-robin arbiter feeding a one-entry registered output buffer.
// Optional grant statistics counters are enabled by defining MUX_ARB_STATS_EN.
module mux_arb_m #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_a,
  input  logic             valid_a,
  output logic             ready_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             valid_b,
  output logic             ready_b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel_a
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0]      gnt_cnt_a,
  output logic [15:0]      gnt_cnt_b
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             sel_a_q, sel_a_d;
  logic             last_a_q, last_a_d;
  logic             can_load;
  logic             gnt_a, gnt_b;

  // Buffer accepts when empty, or when full and being drained this same cycle.
  assign can_load = !rst && ((state_q == EMPTY) || out_ready);

  // last_a_q set means A won most recently, so B wins the next tie.
  assign gnt_a = can_load && valid_a && (!valid_b || !last_a_q);
  assign gnt_b = can_load && valid_b && (!valid_a ||  last_a_q);

  assign ready_a   = gnt_a;
  assign ready_b   = gnt_b;
  assign out       = out_q;
  assign out_valid = (state_q == FULL);
  assign sel_a     = sel_a_q;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    sel_a_d  = sel_a_q;
    last_a_d = last_a_q;
    case (state_q)
      EMPTY: begin
        if (gnt_a || gnt_b) state_d = FULL;
      end
      FULL: begin
        if (gnt_a || gnt_b) state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (gnt_a) begin
      out_d    = data_a;
      sel_a_d  = 1'b1;
      last_a_d = 1'b1;
    end else if (gnt_b) begin
      out_d    = data_b;
      sel_a_d  = 1'b0;
      last_a_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      out_q    <= '0;
      sel_a_q  <= 1'b0;
      last_a_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      sel_a_q  <= sel_a_d;
      last_a_q <= last_a_d;
    end
  end

`ifdef MUX_ARB_STATS_EN
  logic [15:0] cnt_a_q, cnt_a_d;
  logic [15:0] cnt_b_q, cnt_b_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (gnt_a && (cnt_a_q != 16'hFFFF)) cnt_a_d = cnt_a_q + 16'd1;
    if (gnt_b && (cnt_b_q != 16'hFFFF)) cnt_b_d = cnt_b_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= 16'd0;
      cnt_b_q <= 16'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign gnt_cnt_a = cnt_a_q;
  assign gnt_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux_arb_m.sv
// Directed self-checking bench for mux_arb_m; checks use immediate assertions.
module tb_mux_arb_m;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       sel_a;
`ifdef MUX_ARB_STATS_EN
  logic [15:0] gnt_cnt_a, gnt_cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_arb_m #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_a    (data_a),
    .valid_a   (valid_a),
    .ready_a   (ready_a),
    .data_b    (data_b),
    .valid_b   (valid_b),
    .ready_b   (ready_b),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_a     (sel_a)
`ifdef MUX_ARB_STATS_EN
    ,
    .gnt_cnt_a (gnt_cnt_a),
    .gnt_cnt_b (gnt_cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic s, input logic v);
    chk({tag, "_out"}, out, d);
    chk({tag, "_sel"}, sel_a, s);
    chk({tag, "_ov"}, out_valid, v);
    $display("txn %s: out=%02h sel_a=%0b out_valid=%0b", tag, out, sel_a, out_valid);
  endtask

  initial begin
    rst = 1'b1; valid_a = 1'b1; valid_b = 1'b1; data_a = 8'h11; data_b = 8'h22; out_ready = 1'b1;
    #1;
    chk("rst_rdy_a", ready_a, 1'b0);
    chk("rst_rdy_b", ready_b, 1'b0);
    tick(); tick();
    chk_out("reset", 8'h00, 1'b0, 1'b0);

    // Single A request
    rst = 1'b0; valid_a = 1'b1; data_a = 8'hA5; valid_b = 1'b0; out_ready = 1'b1;
    #1;
    chk("single_rdy_a", ready_a, 1'b1);
    chk("single_rdy_b", ready_b, 1'b0);
    tick();
    chk_out("single_a", 8'hA5, 1'b1, 1'b1);
    valid_a = 1'b0;
    tick();
    chk_out("drain", 8'hA5, 1'b1, 1'b0);
    tick();
    chk_out("idle", 8'hA5, 1'b1, 1'b0);

    // Alternation under continuous contention, starting from reset
    rst = 1'b1; tick(); rst = 1'b0;
    valid_a = 1'b1; valid_b = 1'b1; data_a = 8'hFF; data_b = 8'h00; out_ready = 1'b1;
    tick(); chk_out("rr0", 8'hFF, 1'b1, 1'b1);
    tick(); chk_out("rr1", 8'h00, 1'b0, 1'b1);
    tick(); chk_out("rr2", 8'hFF, 1'b1, 1'b1);
    tick(); chk_out("rr3", 8'h00, 1'b0, 1'b1);

    // Backpressure: hold 3C while both requesters wait
    valid_b = 1'b0; data_a = 8'h3C;
    tick(); chk_out("load3c", 8'h3C, 1'b1, 1'b1);
    out_ready = 1'b0; valid_a = 1'b1; valid_b = 1'b1; data_b = 8'h55;
    for (int i = 0; i < 3; i++) begin
      data_a = 8'h60 + 8'(i);
      #1;
      chk("bp_rdy_a", ready_a, 1'b0);
      chk("bp_rdy_b", ready_b, 1'b0);
      tick();
      chk_out("bp_hold", 8'h3C, 1'b1, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy_b", ready_b, 1'b1);
    chk("bp_rel_rdy_a", ready_a, 1'b0);
    tick(); chk_out("bp_release", 8'h55, 1'b0, 1'b1);

    // Only B valid for 4 cycles, then a tie goes to A
    valid_a = 1'b0; data_a = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      data_b = 8'h10 + 8'(i);
      #1;
      chk("bonly_rdy_b", ready_b, 1'b1);
      tick();
      chk_out("bonly", 8'h10 + 8'(i), 1'b0, 1'b1);
    end
    valid_a = 1'b1; valid_b = 1'b1; data_a = 8'h77; data_b = 8'h99;
    #1;
    chk("tie_after_b_rdy_a", ready_a, 1'b1);
    tick(); chk_out("tie_after_b", 8'h77, 1'b1, 1'b1);

    // Reset while full and while both requesters contend
    rst = 1'b1;
    #1;
    chk("midrst_rdy_a", ready_a, 1'b0);
    chk("midrst_rdy_b", ready_b, 1'b0);
    tick(); chk_out("midrst", 8'h00, 1'b0, 1'b0);
`ifdef MUX_ARB_STATS_EN
    chk("cnt_a_rst0", gnt_cnt_a, 16'd0);
    chk("cnt_b_rst0", gnt_cnt_b, 16'd0);
`endif
    rst = 1'b0; data_a = 8'hAA; data_b = 8'hBB;
    #1;
    chk("postrst_rdy_a", ready_a, 1'b1);
    tick(); chk_out("postrst_tie", 8'hAA, 1'b1, 1'b1);

    // Empty with nothing valid holds the last word
    valid_a = 1'b0; valid_b = 1'b0; data_a = 8'h01; data_b = 8'h02;
    tick(); chk_out("empty0", 8'hAA, 1'b1, 1'b0);
    tick(); chk_out("empty1", 8'hAA, 1'b1, 1'b0);

`ifdef MUX_ARB_STATS_EN
    rst = 1'b1; tick(); rst = 1'b0;
    valid_a = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    valid_a = 1'b0; valid_b = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    valid_b = 1'b0;
    tick();
    chk("cnt_a5", gnt_cnt_a, 16'd5);
    chk("cnt_b3", gnt_cnt_b, 16'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("cnt_a_rst", gnt_cnt_a, 16'd0);
    chk("cnt_b_rst", gnt_cnt_b, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
